// File: rtl/cp0_except_pkg.sv
// Shared CP0 constants: register numbers, ExcCode / excepttype values, flag and Status/Cause bit positions.
package cp0_except_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // excepttype_o codes; the low five bits double as Cause.ExcCode except for int
  localparam logic [31:0] ET_NONE = 32'h0;
  localparam logic [31:0] ET_INT  = 32'h1;
  localparam logic [31:0] ET_ADEL = 32'h4;
  localparam logic [31:0] ET_ADES = 32'h5;
  localparam logic [31:0] ET_SYS  = 32'h8;
  localparam logic [31:0] ET_BP   = 32'h9;
  localparam logic [31:0] ET_RI   = 32'ha;
  localparam logic [31:0] ET_OV   = 32'hc;
  localparam logic [31:0] ET_TR   = 32'hd;
  localparam logic [31:0] ET_ERET = 32'he;

  localparam logic [4:0] EXC_INT = 5'h0;

  // ex_flags_i bit positions
  localparam int F_ADEL_IF = 0;
  localparam int F_RI      = 1;
  localparam int F_OV      = 2;
  localparam int F_TR      = 3;
  localparam int F_SYS     = 4;
  localparam int F_BP      = 5;
  localparam int F_ADEL_D  = 6;
  localparam int F_ADES    = 7;
  localparam int F_ERET    = 8;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_BEV = 22;
  localparam int CA_TI  = 30;
  localparam int CA_BD  = 31;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with a phase divider; the TI latch exists only when CP0_TIMER_INT_EN is defined.
module cp0_timer
  import cp0_except_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic phase;
  logic inc;
  logic count_wr;
  logic compare_wr;

  assign count_wr   = we && (waddr == REG_COUNT);
  assign compare_wr = we && (waddr == REG_COMPARE);
  assign inc        = (COUNT_DIV == 1) ? 1'b1 : phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      phase   <= 1'b0;
    end else begin
      if (count_wr) begin
        count <= wdata;
        phase <= 1'b0;
      end else begin
        phase <= (COUNT_DIV == 1) ? 1'b0 : ~phase;
        if (inc) count <= count + 32'd1;
      end
      if (compare_wr) compare <= wdata;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic match;
  // A match is the increment that lands Count on Compare, so a static equality never re-fires.
  assign match = inc && !count_wr && ((count + 32'd1) == compare);

  always_ff @(posedge clk) begin
    if (rst)             ti <= 1'b0;
    else if (compare_wr) ti <= 1'b0;
    else if (match)      ti <= 1'b1;
  end
`else
  assign ti = 1'b0;
`endif

endmodule

// File: rtl/cp0_except.sv
// MEM-stage exception prioritisation plus the CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC).
// Optional timer interrupt into IP7 is enabled by defining CP0_TIMER_INT_EN.
module cp0_except
  import cp0_except_pkg::*;
#(
  parameter logic RESET_VECTOR_BEV = 1'b1,
  parameter int   COUNT_DIV        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic        mem_valid_i,
  input  logic        stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_dslot_i,
  input  logic [31:0] mem_badaddr_i,
  input  logic [8:0]  ex_flags_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  logic [7:0]  im;
  logic        exl, ie;
  logic        bd;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exccode;
  logic [31:0] epc, badvaddr;
  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  ip;
  logic        int_pend;
  logic        commit;
  logic [31:0] status_rd, cause_rd;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .we      (we_i),
    .waddr   (waddr_i),
    .wdata   (wdata_i),
    .count   (count),
    .compare (compare),
    .ti      (ti)
  );

  assign ip          = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign int_pend    = ie && !exl && |(ip & im);
  assign timer_int_o = ti;

  // Reset also masks the decode so nothing can commit while reset is held.
  always_comb begin
    excepttype_o = ET_NONE;
    if (mem_valid_i && !rst) begin
      if      (int_pend)                 excepttype_o = ET_INT;
      else if (ex_flags_i[F_ADEL_IF])    excepttype_o = ET_ADEL;
      else if (ex_flags_i[F_RI])         excepttype_o = ET_RI;
      else if (ex_flags_i[F_OV])         excepttype_o = ET_OV;
      else if (ex_flags_i[F_TR])         excepttype_o = ET_TR;
      else if (ex_flags_i[F_SYS])        excepttype_o = ET_SYS;
      else if (ex_flags_i[F_BP])         excepttype_o = ET_BP;
      else if (ex_flags_i[F_ADEL_D])     excepttype_o = ET_ADEL;
      else if (ex_flags_i[F_ADES])       excepttype_o = ET_ADES;
      else if (ex_flags_i[F_ERET])       excepttype_o = ET_ERET;
    end
  end

  assign commit = (excepttype_o != ET_NONE) && !stall_i;
  assign epc_o  = (we_i && waddr_i == REG_EPC) ? wdata_i : epc;

  always_ff @(posedge clk) begin
    if (rst) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      exccode  <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      ip_hw <= int_i;
      if (we_i) begin
        case (waddr_i)
          REG_STATUS: begin
            im  <= wdata_i[15:8];
            exl <= wdata_i[ST_EXL];
            ie  <= wdata_i[ST_IE];
          end
          REG_CAUSE: ip_sw <= wdata_i[9:8];
          REG_EPC:   epc   <= wdata_i;
          default: ;
        endcase
      end
      // Later assignments win, so the exception update overrides a same-edge mtc0.
      if (commit) begin
        if (excepttype_o == ET_ERET) begin
          exl <= 1'b0;
        end else begin
          exccode <= (excepttype_o == ET_INT) ? EXC_INT : excepttype_o[4:0];
          exl     <= 1'b1;
          if (!exl) begin
            epc <= mem_dslot_i ? mem_pc_i - 32'd4 : mem_pc_i;
            bd  <= mem_dslot_i;
          end
          if (excepttype_o == ET_ADEL && ex_flags_i[F_ADEL_IF])
            badvaddr <= mem_pc_i;
          else if (excepttype_o == ET_ADEL || excepttype_o == ET_ADES)
            badvaddr <= mem_badaddr_i;
        end
      end
    end
  end

  always_comb begin
    status_rd          = '0;
    status_rd[ST_BEV]  = RESET_VECTOR_BEV;
    status_rd[15:8]    = im;
    status_rd[ST_EXL]  = exl;
    status_rd[ST_IE]   = ie;
    cause_rd           = '0;
    cause_rd[CA_BD]    = bd;
    cause_rd[CA_TI]    = ti;
    cause_rd[15:8]     = ip;
    cause_rd[6:2]      = exccode;
  end

  always_comb begin
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr;
      REG_COUNT:    rdata_o = count;
      REG_COMPARE:  rdata_o = compare;
      REG_STATUS:   rdata_o = status_rd;
      REG_CAUSE:    rdata_o = cause_rd;
      REG_EPC:      rdata_o = epc;
      default:      rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_except.sv
// Directed CP0 scenarios followed by random traffic, all checked against an architectural model of CP0.
module tb_cp0_except;

`ifdef CP0_TIMER_INT_EN
  localparam bit TI_EN = 1'b1;
`else
  localparam bit TI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic        mem_valid_i, stall_i, mem_dslot_i;
  logic [31:0] mem_pc_i, mem_badaddr_i;
  logic [8:0]  ex_flags_i;
  logic [31:0] excepttype_o, epc_o;
  logic        timer_int_o;

  int n_assert = 0;
  int n_fail   = 0;

  cp0_except #(.RESET_VECTOR_BEV(1'b1), .COUNT_DIV(2)) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .mem_valid_i(mem_valid_i), .stall_i(stall_i),
    .mem_pc_i(mem_pc_i), .mem_dslot_i(mem_dslot_i), .mem_badaddr_i(mem_badaddr_i),
    .ex_flags_i(ex_flags_i), .excepttype_o(excepttype_o), .epc_o(epc_o), .timer_int_o(timer_int_o)
  );

  always #50 clk = ~clk;

  // Architectural CP0 state, kept as plain fields
  bit [7:0]  m_im, m_ip_hw6;
  bit [1:0]  m_ip_sw;
  bit        m_exl, m_ie, m_bd, m_ti, m_phase;
  bit [4:0]  m_exc;
  bit [31:0] m_epc, m_badv, m_count, m_compare;
  // excepttype for each flag bit, listed from highest to lowest priority
  int unsigned code_of [9] = '{4, 'ha, 'hc, 'hd, 8, 9, 4, 5, 'he};

  task automatic m_reset();
    m_im = 0; m_ip_hw6 = 0; m_ip_sw = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_phase = 0; m_exc = 0; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
  endtask

  function automatic bit [7:0] m_ip();
    return {m_ip_hw6[5] | (TI_EN & m_ti), m_ip_hw6[4:0], m_ip_sw};
  endfunction

  function automatic bit [31:0] m_et();
    if (rst || !mem_valid_i) return 0;
    if (m_ie && !m_exl && ((m_ip() & m_im) != 0)) return 1;
    for (int i = 0; i < 9; i++) if (ex_flags_i[i]) return code_of[i];
    return 0;
  endfunction

  function automatic bit [31:0] m_read(input bit [4:0] a);
    case (a)
      8:  return m_badv;
      9:  return m_count;
      11: return m_compare;
      12: return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
      13: return (32'(m_bd) << 31) + (32'(TI_EN & m_ti) << 30) + (32'(m_ip()) << 8) + (32'(m_exc) << 2);
      14: return m_epc;
      default: return 0;
    endcase
  endfunction

  task automatic m_update();
    bit [31:0] et;
    bit old_exl, inc;
    et = m_et();
    old_exl = m_exl;
    if (rst) begin m_reset(); return; end
    if (we_i && waddr_i == 9) begin
      m_count = wdata_i; m_phase = 0;
    end else begin
      inc = m_phase; m_phase = !m_phase;
      if (inc) begin
        m_count = m_count + 1;
        if (m_count == m_compare && TI_EN) m_ti = 1;
      end
    end
    if (we_i && waddr_i == 11) begin m_compare = wdata_i; m_ti = 0; end
    if (we_i && waddr_i == 12) begin m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0]; end
    if (we_i && waddr_i == 13) m_ip_sw = wdata_i[9:8];
    if (we_i && waddr_i == 14) m_epc = wdata_i;
    m_ip_hw6 = {2'b0, int_i};
    if (et != 0 && !stall_i) begin
      if (et == 'he) m_exl = 0;
      else begin
        m_exc = (et == 1) ? 5'd0 : et[4:0];
        m_exl = 1;
        if (!old_exl) begin m_epc = mem_dslot_i ? mem_pc_i - 4 : mem_pc_i; m_bd = mem_dslot_i; end
        if (et == 4 && ex_flags_i[0]) m_badv = mem_pc_i;
        else if (et == 4 || et == 5) m_badv = mem_badaddr_i;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; compare combinational outputs, advance the model, take the edge.
  task automatic cycle();
    #1;
    chk("excepttype", excepttype_o, m_et());
    chk("epc_o", epc_o, (we_i && waddr_i == 14) ? wdata_i : m_epc);
    chk("rdata", rdata_o, m_read(raddr_i));
    chk("timer_int", {31'b0, timer_int_o}, {31'b0, TI_EN & m_ti});
    m_update();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we_i = 0; waddr_i = 0; wdata_i = 0; mem_valid_i = 0; stall_i = 0;
    mem_dslot_i = 0; ex_flags_i = 0; mem_pc_i = 0; mem_badaddr_i = 0;
  endtask

  task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
    idle(); we_i = 1; waddr_i = a; wdata_i = d;
    cycle();
    idle();
  endtask

  task automatic instr(input bit [8:0] f, input bit [31:0] pc, input bit ds);
    idle(); mem_valid_i = 1; ex_flags_i = f; mem_pc_i = pc; mem_dslot_i = ds;
  endtask

  task automatic rchk(input string tag, input bit [4:0] a, input bit [31:0] exp);
    raddr_i = a; #1;
    chk(tag, rdata_o, exp);
  endtask

  initial begin
    rst = 1; int_i = 0; raddr_i = 0; idle();
    @(posedge clk); #1;
    m_reset();
    cycle();
    rst = 0;
    rchk("reset_status", 12, 32'h0040_0000);
    rchk("reset_cause", 13, 0);
    chk("reset_excepttype", excepttype_o, 0);

    // 1: Sys, no delay slot
    instr(9'h010, 32'hbfc0_0100, 0); #1;
    chk("t1_et", excepttype_o, 8);
    cycle(); idle();
    rchk("t1_epc", 14, 32'hbfc0_0100);
    rchk("t1_cause", 13, 32'h0000_0020);
    rchk("t1_status", 12, 32'h0040_0002);

    // 2: Ov in delay slot
    mtc0(12, 0);
    instr(9'h004, 32'h8000_0010, 1); cycle(); idle();
    rchk("t2_epc", 14, 32'h8000_000c);
    rchk("t2_cause", 13, 32'h8000_0030);

    // 3: RI beats Sys; then Bp with EXL already set
    instr(9'h012, 32'h8000_0100, 0); #1;
    chk("t3_et", excepttype_o, 'ha);
    cycle(); idle();
    rchk("t3_cause", 13, 32'h8000_0028);
    instr(9'h020, 32'h8000_0200, 0); cycle(); idle();
    rchk("t3_bp_epc", 14, 32'h8000_000c);
    rchk("t3_bp_cause", 13, 32'h8000_0024);

    // AdEL on fetch records the PC in BadVAddr; mtc0 to BadVAddr is dropped
    mtc0(12, 0);
    instr(9'h001, 32'h8000_0123, 0); mem_badaddr_i = 32'h1111_1111; cycle(); idle();
    rchk("adel_badv", 8, 32'h8000_0123);
    mtc0(8, 32'hffff_ffff);
    rchk("badv_ro", 8, 32'h8000_0123);

    // 4: interrupt, then masked by EXL
    mtc0(12, 32'h0000_0401);
    int_i = 6'h01; cycle();
    instr(0, 32'h8000_1000, 0); #1;
    chk("t4_int", excepttype_o, 1);
    cycle();
    instr(0, 32'h8000_1004, 0); #1;
    chk("t4_int_exl", excepttype_o, 0);
    cycle(); idle(); int_i = 0;
    rchk("t4_epc", 14, 32'h8000_1000);

    // 5: timer
    mtc0(11, 5);
    mtc0(9, 0);
    for (int i = 0; i < 9; i++) cycle();
    chk("t5_ti_early", {31'b0, timer_int_o}, 0);
    cycle();
    chk("t5_ti", {31'b0, timer_int_o}, {31'b0, TI_EN});
    rchk("t5_count", 9, 5);
    mtc0(11, 1000);
    chk("t5_ti_clr", {31'b0, timer_int_o}, 0);

    // 6: eret with same-cycle EPC write
    mtc0(12, 2);
    instr(9'h100, 32'h8000_2000, 0); we_i = 1; waddr_i = 14; wdata_i = 32'h1234_5678; #1;
    chk("t6_epc_byp", epc_o, 32'h1234_5678);
    chk("t6_et", excepttype_o, 'he);
    cycle(); idle();
    rchk("t6_status", 12, 32'h0040_0000);

    // reset in the middle of a stall
    instr(9'h010, 32'h8000_3000, 0); stall_i = 1; #1;
    chk("stall_et", excepttype_o, 8);
    cycle();
    rchk("stall_epc", 14, 32'h1234_5678);
    rst = 1; cycle(); rst = 0; idle();
    rchk("rst_status", 12, 32'h0040_0000);
    rchk("rst_cause", 13, 0);
    rchk("rst_epc", 14, 0);
    rchk("rst_badv", 8, 0);
    rchk("rst_count", 9, 0);
    rchk("rst_compare", 11, 0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit [4:0] regs [8] = '{8, 9, 11, 12, 13, 14, 3, 12};
      idle();
      we_i = ($urandom_range(0, 3) == 0);
      waddr_i = regs[$urandom_range(0, 7)];
      wdata_i = $urandom;
      if (waddr_i == 9 || waddr_i == 11) wdata_i = wdata_i & 32'h0000_003f;
      raddr_i = regs[$urandom_range(0, 7)];
      mem_valid_i = ($urandom_range(0, 3) != 0);
      stall_i = ($urandom_range(0, 3) == 0);
      mem_pc_i = $urandom & 32'hffff_fffc;
      mem_dslot_i = $urandom_range(0, 1);
      mem_badaddr_i = $urandom;
      for (int b = 0; b < 9; b++) ex_flags_i[b] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) int_i = 6'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
